// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module   : router_pkt_tx
//  Purpose  : Packet source for a 3-port router. Payload bytes are staged in
//             a 64x8 buffer while idle; a start request then streams a
//             header byte {pay_len, dest_addr}, pay_len payload bytes and an
//             XOR parity byte, honouring the router's busy back-pressure.
//             Two CHECK cycles follow before done is pulsed.
//  Ports    : clock, reset (sync, active-high)
//             wr_en/wr_data    - payload buffer write (IDLE only)
//             start/dest_addr/pay_len - packet request (IDLE only)
//             busy             - router stall, byte held while high
//             error            - router parity-error indication
//             pkt_valid/data_in - byte stream to router
//             ready/done/req_err/pkt_err - status (all registered)
//  Config   : `define ROUTER_TX_ERRCHK_EN samples error during the CHECK
//             cycles and reports it on pkt_err; otherwise pkt_err stays 0.
//  Revision : 1.0 - initial release
// ============================================================================
module router_pkt_tx (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pay_len,
    input  logic       busy,
    input  logic       error,
    output logic       pkt_valid,
    output logic [7:0] data_in,
    output logic       ready,
    output logic       done,
    output logic       req_err,
    output logic       pkt_err
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_HEADER  = 3'd1;
    localparam logic [2:0] c_ST_PAYLOAD = 3'd2;
    localparam logic [2:0] c_ST_PARITY  = 3'd3;
    localparam logic [2:0] c_ST_CHECK   = 3'd4;

    localparam logic [6:0] c_BUF_DEPTH  = 7'd64;

    logic [7:0] r_buf [0:63];

    logic [2:0] r_state,     w_state_nxt;
    logic [6:0] r_wr_cnt,    w_wr_cnt_nxt;
    logic [5:0] r_idx,       w_idx_nxt;
    logic [5:0] r_len,       w_len_nxt;
    logic [7:0] r_par,       w_par_nxt;
    logic       r_chk,       w_chk_nxt;
    logic       r_pkt_valid, w_pkt_valid_nxt;
    logic [7:0] r_data_in,   w_data_in_nxt;
    logic       r_ready,     w_ready_nxt;
    logic       r_done,      w_done_nxt;
    logic       r_req_err,   w_req_err_nxt;
    logic       r_pkt_err,   w_pkt_err_nxt;
`ifdef ROUTER_TX_ERRCHK_EN
    logic       r_err_seen,  w_err_seen_nxt;
`else
    logic       w_unused;
    assign w_unused = error;
`endif

    logic       w_wr_accept;
    logic       w_start_bad;
    logic       w_last;
    logic [7:0] w_nxt_byte;

    // Writes beyond the 64th are silently dropped (counter saturates).
    assign w_wr_accept = (r_state == c_ST_IDLE) && wr_en && (r_wr_cnt != c_BUF_DEPTH);
    assign w_start_bad = (dest_addr == 2'd3) || (pay_len == 6'd0) ||
                         ({1'b0, pay_len} > r_wr_cnt);
    assign w_last      = (r_idx == (r_len - 6'd1));
    assign w_nxt_byte  = r_buf[r_idx + 6'd1];

    always_ff @(posedge clock) begin
        if (!reset && w_wr_accept) begin
            r_buf[r_wr_cnt[5:0]] <= wr_data;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wr_cnt_nxt    = r_wr_cnt;
        w_idx_nxt       = r_idx;
        w_len_nxt       = r_len;
        w_par_nxt       = r_par;
        w_chk_nxt       = r_chk;
        w_pkt_valid_nxt = r_pkt_valid;
        w_data_in_nxt   = r_data_in;
        w_ready_nxt     = r_ready;
        w_done_nxt      = 1'b0;
        w_req_err_nxt   = 1'b0;
        w_pkt_err_nxt   = 1'b0;
`ifdef ROUTER_TX_ERRCHK_EN
        w_err_seen_nxt  = r_err_seen;
`endif
        case (r_state)
            c_ST_IDLE: begin
                w_pkt_valid_nxt = 1'b0;
                w_data_in_nxt   = 8'h00;
                w_ready_nxt     = 1'b1;
                if (w_wr_accept) begin
                    w_wr_cnt_nxt = r_wr_cnt + 7'd1;
                end
                if (start) begin
                    if (w_start_bad) begin
                        w_req_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = c_ST_HEADER;
                        w_len_nxt       = pay_len;
                        w_par_nxt       = {pay_len, dest_addr};
                        w_data_in_nxt   = {pay_len, dest_addr};
                        w_pkt_valid_nxt = 1'b1;
                        w_ready_nxt     = 1'b0;
                    end
                end
            end
            c_ST_HEADER: begin
                if (!busy) begin
                    w_state_nxt   = c_ST_PAYLOAD;
                    w_idx_nxt     = 6'd0;
                    w_data_in_nxt = r_buf[6'd0];
                end
            end
            c_ST_PAYLOAD: begin
                if (!busy) begin
                    // r_data_in is the byte being consumed; fold it in.
                    w_par_nxt = r_par ^ r_data_in;
                    if (w_last) begin
                        w_state_nxt     = c_ST_PARITY;
                        w_data_in_nxt   = r_par ^ r_data_in;
                        w_pkt_valid_nxt = 1'b0;
                    end else begin
                        w_idx_nxt     = r_idx + 6'd1;
                        w_data_in_nxt = w_nxt_byte;
                    end
                end
            end
            c_ST_PARITY: begin
                if (!busy) begin
                    w_state_nxt   = c_ST_CHECK;
                    w_data_in_nxt = 8'h00;
                    w_chk_nxt     = 1'b0;
`ifdef ROUTER_TX_ERRCHK_EN
                    w_err_seen_nxt = 1'b0;
`endif
                end
            end
            c_ST_CHECK: begin
                w_chk_nxt = 1'b1;
`ifdef ROUTER_TX_ERRCHK_EN
                w_err_seen_nxt = r_err_seen | error;
`endif
                if (r_chk) begin
                    w_state_nxt  = c_ST_IDLE;
                    w_chk_nxt    = 1'b0;
                    w_ready_nxt  = 1'b1;
                    w_done_nxt   = 1'b1;
                    w_wr_cnt_nxt = 7'd0;
`ifdef ROUTER_TX_ERRCHK_EN
                    w_pkt_err_nxt = r_err_seen | error;
`endif
                end
            end
            default: begin
                w_state_nxt     = c_ST_IDLE;
                w_pkt_valid_nxt = 1'b0;
                w_data_in_nxt   = 8'h00;
                w_ready_nxt     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_wr_cnt    <= 7'd0;
            r_idx       <= 6'd0;
            r_len       <= 6'd0;
            r_par       <= 8'h00;
            r_chk       <= 1'b0;
            r_pkt_valid <= 1'b0;
            r_data_in   <= 8'h00;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_req_err   <= 1'b0;
            r_pkt_err   <= 1'b0;
`ifdef ROUTER_TX_ERRCHK_EN
            r_err_seen  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_len       <= w_len_nxt;
            r_par       <= w_par_nxt;
            r_chk       <= w_chk_nxt;
            r_pkt_valid <= w_pkt_valid_nxt;
            r_data_in   <= w_data_in_nxt;
            r_ready     <= w_ready_nxt;
            r_done      <= w_done_nxt;
            r_req_err   <= w_req_err_nxt;
            r_pkt_err   <= w_pkt_err_nxt;
`ifdef ROUTER_TX_ERRCHK_EN
            r_err_seen  <= w_err_seen_nxt;
`endif
        end
    end

    assign pkt_valid = r_pkt_valid;
    assign data_in   = r_data_in;
    assign ready     = r_ready;
    assign done      = r_done;
    assign req_err   = r_req_err;
    assign pkt_err   = r_pkt_err;

endmodule
`default_nettype wire
